// File: rtl/datamemory_dp.sv
// Simple-dual-port RAM: one byte-masked write port, one read port, common clock.
// readValid pulses once per accepted read; there is no ready, so reads never stall.
module datamemory_dp #(
  parameter int addresswidth = 8,
  parameter int depth        = 2**addresswidth,
  parameter int width        = 32,
  parameter int readlatency  = 1,
  parameter int rdwmode      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeEnable,
  input  logic [addresswidth-1:0] writeAddress,
  input  logic [width-1:0]        dataIn,
  input  logic [width/8-1:0]      byteEnable,
  input  logic                    readEnable,
  input  logic [addresswidth-1:0] readAddress,
  output logic [width-1:0]        dataOut,
  output logic                    readValid,
  output logic                    collision
);

  localparam int lanes = width / 8;
  localparam logic [addresswidth:0] depth_lim = (addresswidth + 1)'(depth);

  if (readlatency != 1 && readlatency != 2) begin : g_bad_latency
    $error("datamemory_dp: readlatency must be 1 or 2");
  end
  if ((width % 8) != 0 || width < 8) begin : g_bad_width
    $error("datamemory_dp: width must be a non-zero multiple of 8");
  end
  if (depth < 1 || depth > 2**addresswidth) begin : g_bad_depth
    $error("datamemory_dp: depth must be in 1..2**addresswidth");
  end

  logic [width-1:0] mem [depth];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_active;
  logic             hit;
  logic [width-1:0] old_word;
  logic [width-1:0] merged_word;
  logic [width-1:0] rd_word;

  always_comb begin
    wr_in_range = ({1'b0, writeAddress} < depth_lim);
    rd_in_range = ({1'b0, readAddress} < depth_lim);
    wr_active   = writeEnable && wr_in_range && (byteEnable != '0);
    hit         = wr_active && readEnable && rd_in_range && (readAddress == writeAddress);
    old_word    = rd_in_range ? mem[readAddress] : '0;
    merged_word = old_word;
    for (int i = 0; i < lanes; i++) begin
      if (byteEnable[i]) merged_word[8*i +: 8] = dataIn[8*i +: 8];
    end
    // Only a same-address write can change what the read returns.
    rd_word = (hit && rdwmode != 0) ? merged_word : old_word;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (writeEnable && wr_in_range) begin
      for (int i = 0; i < lanes; i++) begin
        if (byteEnable[i]) mem[writeAddress][8*i +: 8] <= dataIn[8*i +: 8];
      end
    end
  end

  logic             s1_valid;
  logic             s1_coll;
  logic [width-1:0] s1_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= readEnable;
      s1_coll  <= hit;
      if (readEnable) s1_data <= rd_word;
    end
  end

  if (readlatency == 2) begin : g_lat2
    logic             s2_valid;
    logic             s2_coll;
    logic [width-1:0] s2_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_coll  <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_coll;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign dataOut   = s2_data;
    assign readValid = s2_valid;
    assign collision = s2_coll;
  end else begin : g_lat1
    assign dataOut   = s1_data;
    assign readValid = s1_valid;
    assign collision = s1_coll;
  end

endmodule

// File: tb/tb_datamemory_dp.sv
// Bench for datamemory_dp: two instances (latency 1/old-data/full depth and
// latency 2/new-data/depth 200) share one stimulus stream and a word-level model.
module tb_datamemory_dp;

  localparam int W  = 32;
  localparam int AW = 8;

  typedef struct packed {
    int         due;
    logic [W-1:0] data;
    logic       coll;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [AW-1:0] wa  = '0;
  logic [AW-1:0] ra  = '0;
  logic [W-1:0]  din = '0;
  logic [3:0]    be  = '0;

  logic [W-1:0]  dout_a, dout_b;
  logic          vld_a, vld_b, col_a, col_b;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;

  int            lat [2] = '{1, 2};
  int            rdw [2] = '{0, 1};
  int            dep [2] = '{256, 200};
  logic [W-1:0]  mdl_mem [2][256];
  logic [W-1:0]  last [2];
  rd_t           q_a[$];
  rd_t           q_b[$];

  datamemory_dp #(.addresswidth(AW), .depth(256), .width(W), .readlatency(1), .rdwmode(0)) u_dut_a (
    .clk(clk), .reset(rst), .writeEnable(we), .writeAddress(wa), .dataIn(din), .byteEnable(be),
    .readEnable(re), .readAddress(ra), .dataOut(dout_a), .readValid(vld_a), .collision(col_a)
  );

  datamemory_dp #(.addresswidth(AW), .depth(200), .width(W), .readlatency(2), .rdwmode(1)) u_dut_b (
    .clk(clk), .reset(rst), .writeEnable(we), .writeAddress(wa), .dataIn(din), .byteEnable(be),
    .readEnable(re), .readAddress(ra), .dataOut(dout_b), .readValid(vld_b), .collision(col_b)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Mask arithmetic: enabled lanes from new data, others from old word.
  function automatic logic [W-1:0] merge(logic [W-1:0] old, logic [W-1:0] d, logic [3:0] b);
    logic [W-1:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic check_dut(int d, logic v, logic [W-1:0] data, logic c);
    rd_t   e;
    bit    due;
    string n;
    n   = (d == 0) ? "a" : "b";
    due = 0;
    e   = '0;
    if (d == 0) begin
      if (q_a.size() > 0 && q_a[0].due == cyc) begin e = q_a.pop_front(); due = 1; end
    end else begin
      if (q_b.size() > 0 && q_b[0].due == cyc) begin e = q_b.pop_front(); due = 1; end
    end
    if (due) last[d] = e.data;
    check({n, "_valid"}, W'(v), W'(due));
    check({n, "_data"}, data, last[d]);
    check({n, "_coll"}, W'(c), due ? W'(e.coll) : '0);
  endtask

  task automatic step(bit w, int wadr, logic [W-1:0] d, logic [3:0] b, bit r, int radr);
    rd_t e;
    we = w; wa = AW'(wadr); din = d; be = b; re = r; ra = AW'(radr);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        e.due = cyc + lat[k];
        if (radr >= dep[k]) begin
          e.data = '0;
          e.coll = 1'b0;
        end else begin
          e.coll = w && (wadr == radr) && (b != 4'h0);
          e.data = (e.coll && rdw[k] == 1) ? merge(mdl_mem[k][radr], d, b) : mdl_mem[k][radr];
        end
        if (k == 0) q_a.push_back(e); else q_b.push_back(e);
      end
      if (w && wadr < dep[k]) mdl_mem[k][wadr] = merge(mdl_mem[k][wadr], d, b);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_dut(0, vld_a, dout_a, col_a);
    check_dut(1, vld_b, dout_b, col_b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 4'h0, 0, 0);
  endtask

  task automatic apply_reset_mid();
    we = 0; re = 0; be = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_a_valid", W'(vld_a), '0);
    check("rst_a_data", dout_a, '0);
    check("rst_a_coll", W'(col_a), '0);
    check("rst_b_valid", W'(vld_b), '0);
    check("rst_b_data", dout_b, '0);
    check("rst_b_coll", W'(col_b), '0);
    q_a.delete();
    q_b.delete();
    last[0] = '0;
    last[1] = '0;
    @(posedge clk);
    #1;
    cyc++;
    check_dut(0, vld_a, dout_a, col_a);
    check_dut(1, vld_b, dout_b, col_b);
    rst = 1'b0;
  endtask

  initial begin
    int wadr, radr;
    last[0] = '0;
    last[1] = '0;
    #1 rst = 1'b1;
    #1;
    check("init_a_valid", W'(vld_a), '0);
    check("init_a_data", dout_a, '0);
    check("init_a_coll", W'(col_a), '0);
    check("init_b_valid", W'(vld_b), '0);
    check("init_b_data", dout_b, '0);
    check("init_b_coll", W'(col_b), '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int a = 0; a < 256; a++) step(1, a, W'($urandom), 4'hF, 0, 0);

    // Write then read next cycle.
    step(1, 3, 32'hDEADBEEF, 4'hF, 0, 0);
    step(0, 0, '0, 4'h0, 1, 3);
    idle(3);
    check("t1_a_word", dout_a, 32'hDEADBEEF);
    check("t1_b_word", dout_b, 32'hDEADBEEF);

    // Partial byte write.
    step(1, 5, 32'h11223344, 4'hF, 0, 0);
    step(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0);
    step(0, 0, '0, 4'h0, 1, 5);
    idle(3);
    check("t2_a_word", dout_a, 32'h11BB33DD);
    check("t2_b_word", dout_b, 32'h11BB33DD);

    // Read during write to the same address.
    step(1, 7, 32'h00000000, 4'hF, 0, 0);
    step(1, 7, 32'hFFFFFFFF, 4'hF, 1, 7);
    idle(3);
    check("t3_a_old", dout_a, 32'h00000000);
    check("t3_b_new", dout_b, 32'hFFFFFFFF);

    // Back-to-back burst.
    for (int a = 0; a < 16; a++) step(1, a, W'(a) * 32'h01010101, 4'hF, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 0, '0, 4'h0, 1, a);
    idle(3);
    check("t4_a_last", dout_a, 32'h0F0F0F0F);
    check("t4_b_last", dout_b, 32'h0F0F0F0F);

    // Reset with reads in flight, then confirm memory survived.
    step(0, 0, '0, 4'h0, 1, 12);
    step(0, 0, '0, 4'h0, 1, 13);
    apply_reset_mid();
    idle(3);
    step(0, 0, '0, 4'h0, 1, 12);
    step(0, 0, '0, 4'h0, 1, 13);
    idle(3);
    check("t5_a_kept", dout_a, 32'h0D0D0D0D);
    check("t5_b_kept", dout_b, 32'h0D0D0D0D);

    // Out-of-range on the depth-200 instance.
    step(1, 199, 32'hC0FFEE99, 4'hF, 0, 0);
    step(1, 250, 32'h5A5A5A5A, 4'hF, 0, 0);
    step(0, 0, '0, 4'h0, 1, 250);
    idle(3);
    check("t6_b_oor", dout_b, 32'h00000000);
    check("t6_a_inrange", dout_a, 32'h5A5A5A5A);
    step(0, 0, '0, 4'h0, 1, 199);
    idle(3);
    check("t6_b_199", dout_b, 32'hC0FFEE99);

    // Random traffic concentrated on a few addresses to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset_mid();
      end else begin
        wadr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
        radr = ($urandom_range(0, 3) == 0) ? wadr
             : (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15)));
        step(1'($urandom_range(0, 1)), wadr, W'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), radr);
      end
    end
    idle(3);
    check("end_a_queue_empty", W'(q_a.size()), '0);
    check("end_b_queue_empty", W'(q_b.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
